// File: rtl/pll_md_pkg.sv
// +----------------------------------------------------------------------------+
// | pll_md_pkg: shared MD-port opcodes, controller states and default timings   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package pll_md_pkg;

    localparam logic [1:0] MD_NOP = 2'b00;
    localparam logic [1:0] MD_WR  = 2'b01;
    localparam logic [1:0] MD_RD  = 2'b10;
    localparam logic [1:0] MD_CLR = 2'b11;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR_CLR  = 3'd1;
    localparam logic [2:0] ST_ADDR_STEP = 3'd2;
    localparam logic [2:0] ST_ACCESS    = 3'd3;
    localparam logic [2:0] ST_READ_WAIT = 3'd4;
    localparam logic [2:0] ST_PLL_RST   = 3'd5;
    localparam logic [2:0] ST_LOCK_WAIT = 3'd6;
    localparam logic [2:0] ST_RESP      = 3'd7;

    localparam int DEF_RD_LAT       = 2;
    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT = 65535;

endpackage

`default_nettype wire

// File: rtl/pll_md_ctrl_sync2.sv
// +----------------------------------------------------------------------------+
// | sync2: two-flop synchroniser for slow asynchronous level signals            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_md_ctrl.sv
// +----------------------------------------------------------------------------+
// | pll_md_ctrl: host-driven initiator for the PLL dynamic-reconfig (MD) port   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module pll_md_ctrl
    import pll_md_pkg::*;
#(
    parameter int ADDR_W          = 7,
    parameter int RD_LAT          = DEF_RD_LAT,
    parameter int RST_CYCLES      = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter bit RELOCK_ON_WRITE = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [1:0]        md_opc,
    output logic              md_ainc,
    output logic [7:0]        md_wdi,
    input  logic [7:0]        md_rdo
);

    localparam logic [15:0] c_rd_last  = 16'(RD_LAT - 1);
    localparam logic [15:0] c_rst_last = 16'(RST_CYCLES - 1);
    localparam logic [15:0] c_to_last  = 16'(LOCK_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_cur_addr;
    logic              r_addr_known;
    logic [ADDR_W-1:0] r_steps;
    logic [ADDR_W-1:0] w_steps_nxt;
    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nxt;
    logic              w_lock_s;
    logic              w_accept;
    logic              w_write_nxt;
    logic [1:0]        w_opc_nxt;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [7:0]        r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_pll_reset;
    logic [1:0]        r_md_opc;
    logic              r_md_ainc;
    logic [7:0]        r_md_wdi;

    sync2 #(.WIDTH(1)) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (pll_lock),
        .o_q    (w_lock_s)
    );

    assign w_accept    = req_valid & r_req_ready;
    assign w_write_nxt = w_accept ? req_write : r_write;

    always_comb begin
        w_state_nxt = r_state;
        w_steps_nxt = r_steps;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Forward-only stepping: a backward target needs a clear first.
                    if (r_addr_known && (req_addr >= r_cur_addr)) begin
                        w_steps_nxt = req_addr - r_cur_addr;
                        w_state_nxt = (w_steps_nxt == '0) ? ST_ACCESS : ST_ADDR_STEP;
                    end else begin
                        w_state_nxt = ST_ADDR_CLR;
                    end
                end
            end
            ST_ADDR_CLR: begin
                w_steps_nxt = r_addr;
                w_state_nxt = (r_addr == '0) ? ST_ACCESS : ST_ADDR_STEP;
            end
            ST_ADDR_STEP: begin
                w_steps_nxt = r_steps - 1'b1;
                if (r_steps == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_cnt_nxt = '0;
                if (!r_write) begin
                    w_state_nxt = ST_READ_WAIT;
                end else if (RELOCK_ON_WRITE) begin
                    w_state_nxt = ST_PLL_RST;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_READ_WAIT: begin
                if (r_cnt == c_rd_last) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PLL_RST: begin
                if (r_cnt == c_rst_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_LOCK_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_LOCK_WAIT: begin
                // Lock is tested before the timeout so a simultaneous lock wins.
                if (w_lock_s || (r_cnt == c_to_last)) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_opc_nxt = MD_NOP;
        case (w_state_nxt)
            ST_ADDR_CLR: w_opc_nxt = MD_CLR;
            ST_ACCESS:   w_opc_nxt = w_write_nxt ? MD_WR : MD_RD;
            default:     w_opc_nxt = MD_NOP;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_cur_addr   <= '0;
            r_addr_known <= 1'b0;
            r_steps      <= '0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 8'h00;
            r_rsp_err    <= 1'b0;
            r_pll_reset  <= 1'b0;
            r_md_opc     <= MD_NOP;
            r_md_ainc    <= 1'b0;
            r_md_wdi     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_steps <= w_steps_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                if (req_write) begin
                    r_md_wdi <= req_wdata;
                end
            end
            if (r_state == ST_ADDR_CLR) begin
                r_cur_addr   <= '0;
                r_addr_known <= 1'b1;
            end else if (r_state == ST_ADDR_STEP) begin
                r_cur_addr <= r_cur_addr + 1'b1;
            end
            if ((r_state == ST_READ_WAIT) && (r_cnt == c_rd_last)) begin
                r_rsp_rdata <= md_rdo;
            end
            if (w_state_nxt == ST_RESP) begin
                r_rsp_err <= (r_state == ST_LOCK_WAIT) && !w_lock_s;
            end
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_pll_reset <= (w_state_nxt == ST_PLL_RST);
            r_md_ainc   <= (w_state_nxt == ST_ADDR_STEP);
            r_md_opc    <= w_opc_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign pll_reset = r_pll_reset;
    assign md_opc    = r_md_opc;
    assign md_ainc   = r_md_ainc;
    assign md_wdi    = r_md_wdi;

endmodule

`default_nettype wire

// File: tb/tb_pll_md_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_pll_md_ctrl: directed bench for pll_md_ctrl with PLL read/lock models    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pll_md_ctrl;
    import pll_md_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_valid_a, req_valid_b;

    logic       req_ready_a, rsp_valid_a, rsp_err_a, pll_reset_a, md_ainc_a;
    logic [7:0] rsp_rdata_a, md_wdi_a, md_rdo_a;
    logic [1:0] md_opc_a;
    logic       pll_lock_a = 1'b1;

    logic       req_ready_b, rsp_valid_b, rsp_err_b, pll_reset_b, md_ainc_b;
    logic [7:0] rsp_rdata_b, md_wdi_b;
    logic [1:0] md_opc_b;
    logic [7:0] md_rdo_b = 8'h77;
    logic       pll_lock_b = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_md_ctrl #(
        .ADDR_W(7), .RD_LAT(2), .RST_CYCLES(16), .LOCK_TIMEOUT(65535), .RELOCK_ON_WRITE(1'b0)
    ) u_dut_a (
        .clk(clk), .resetn(resetn), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .pll_lock(pll_lock_a), .pll_reset(pll_reset_a), .md_opc(md_opc_a),
        .md_ainc(md_ainc_a), .md_wdi(md_wdi_a), .md_rdo(md_rdo_a)
    );

    pll_md_ctrl #(
        .ADDR_W(7), .RD_LAT(2), .RST_CYCLES(16), .LOCK_TIMEOUT(100), .RELOCK_ON_WRITE(1'b1)
    ) u_dut_b (
        .clk(clk), .resetn(resetn), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .pll_lock(pll_lock_b), .pll_reset(pll_reset_b), .md_opc(md_opc_b),
        .md_ainc(md_ainc_b), .md_wdi(md_wdi_b), .md_rdo(md_rdo_b)
    );

    // PLL read model: data valid exactly RD_LAT=2 cycles after the read opcode.
    logic [7:0] rd_val = 8'h00;
    logic       rd_p1 = 1'b0, rd_p2 = 1'b0;
    always @(posedge clk) begin
        rd_p1 <= (md_opc_a == MD_RD);
        rd_p2 <= rd_p1;
    end
    assign md_rdo_a = rd_p2 ? rd_val : 8'hEE;

    // PLL lock model: drops during reset, relocks 40 cycles after reset release.
    logic lk_en  = 1'b0;
    int   lk_cnt = 0;
    always @(posedge clk) begin
        if (pll_reset_b) begin
            pll_lock_b <= 1'b0;
            lk_cnt     <= 0;
        end else if (!pll_lock_b && lk_en) begin
            if (lk_cnt == 39) pll_lock_b <= 1'b1;
            lk_cnt <= lk_cnt + 1;
        end
    end

    logic       sel = 1'b0;
    logic       m_ready, m_rvalid, m_err, m_prst, m_ainc;
    logic [7:0] m_rdata, m_wdi;
    logic [1:0] m_opc;
    assign m_ready  = sel ? req_ready_b : req_ready_a;
    assign m_rvalid = sel ? rsp_valid_b : rsp_valid_a;
    assign m_err    = sel ? rsp_err_b   : rsp_err_a;
    assign m_prst   = sel ? pll_reset_b : pll_reset_a;
    assign m_ainc   = sel ? md_ainc_b   : md_ainc_a;
    assign m_rdata  = sel ? rsp_rdata_b : rsp_rdata_a;
    assign m_wdi    = sel ? md_wdi_b    : md_wdi_a;
    assign m_opc    = sel ? md_opc_b    : md_opc_a;

    int         clr_n, clr_first, ainc_n, ainc_first, ainc_last;
    int         acc_n, acc_cyc, prst_n, prst_first, rsp_cyc, overlap, rdy_busy;
    logic [1:0] acc_opc;
    logic [7:0] acc_wdi, rsp_rd;
    logic       rsp_er;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, m_ready}, 32'd1);
    endtask

    // Issues one request and records per-cycle MD activity; cycle 1 follows acceptance.
    task automatic run_req(input logic b, input logic wr, input logic [6:0] addr, input logic [7:0] wd);
        sel = b;
        wait_ready();
        req_write = wr; req_addr = addr; req_wdata = wd;
        if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_addr = 7'h55; req_wdata = 8'h00; req_write = ~wr;
        clr_n = 0; clr_first = 0; ainc_n = 0; ainc_first = 0; ainc_last = 0;
        acc_n = 0; acc_cyc = 0; prst_n = 0; prst_first = 0; rsp_cyc = 0;
        overlap = 0; rdy_busy = 0; acc_opc = 2'b00; acc_wdi = 8'h00; rsp_rd = 8'h00; rsp_er = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (m_opc == MD_CLR) begin
                clr_n++;
                if (clr_first == 0) clr_first = n;
            end else if (m_opc != MD_NOP) begin
                acc_n++; acc_cyc = n; acc_opc = m_opc; acc_wdi = m_wdi;
            end
            if (m_ainc) begin
                ainc_n++; ainc_last = n;
                if (ainc_first == 0) ainc_first = n;
                if (m_opc != MD_NOP) overlap++;
            end
            if (m_prst) begin
                prst_n++;
                if (prst_first == 0) prst_first = n;
            end
            if (m_ready) rdy_busy++;
            if (m_rvalid) begin
                rsp_cyc = n; rsp_rd = m_rdata; rsp_er = m_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, m_rvalid}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {req_ready_a, rsp_valid_a, rsp_rdata_a, rsp_err_a, pll_reset_a, md_opc_a, md_ainc_a, md_wdi_a}, 0);
        chk("rst_outs_b", {req_ready_b, rsp_valid_b, rsp_rdata_b, rsp_err_b, pll_reset_b, md_opc_b, md_ainc_b, md_wdi_b}, 0);
        resetn = 1'b1;
        #1;
        chk("ready_first_cycle", {31'd0, req_ready_a}, 0);
        @(negedge clk);
        chk("ready_second_cycle", {31'd0, req_ready_a}, 1);

        // Write addr 5 from unknown address, no relock.
        run_req(1'b0, 1'b1, 7'd5, 8'h3C);
        chk("w5_clr_n", clr_n, 1);       chk("w5_clr_first", clr_first, 1);
        chk("w5_ainc_n", ainc_n, 5);     chk("w5_ainc_first", ainc_first, 2);
        chk("w5_ainc_last", ainc_last, 6);
        chk("w5_acc_n", acc_n, 1);       chk("w5_acc_cyc", acc_cyc, 7);
        chk("w5_acc_opc", acc_opc, MD_WR); chk("w5_wdi", acc_wdi, 8'h3C);
        chk("w5_rsp_cyc", rsp_cyc, 8);   chk("w5_err", rsp_er, 0);
        chk("w5_overlap", overlap, 0);   chk("w5_ready_busy", rdy_busy, 0);

        // Forward read 5 -> 9.
        rd_val = 8'hA5;
        run_req(1'b0, 1'b0, 7'd9, 8'h00);
        chk("r9_clr_n", clr_n, 0);       chk("r9_ainc_n", ainc_n, 4);
        chk("r9_ainc_first", ainc_first, 1); chk("r9_ainc_last", ainc_last, 4);
        chk("r9_acc_cyc", acc_cyc, 5);   chk("r9_acc_opc", acc_opc, MD_RD);
        chk("r9_rsp_cyc", rsp_cyc, 8);   chk("r9_rdata", rsp_rd, 8'hA5);

        // Backward read 9 -> 3 needs a clear.
        rd_val = 8'h5A;
        run_req(1'b0, 1'b0, 7'd3, 8'h00);
        chk("r3_clr_n", clr_n, 1);       chk("r3_clr_first", clr_first, 1);
        chk("r3_ainc_n", ainc_n, 3);     chk("r3_ainc_first", ainc_first, 2);
        chk("r3_acc_cyc", acc_cyc, 5);   chk("r3_rsp_cyc", rsp_cyc, 8);
        chk("r3_rdata", rsp_rd, 8'h5A);

        // Same address again: no clear, no strobes.
        rd_val = 8'hC3;
        run_req(1'b0, 1'b0, 7'd3, 8'h00);
        chk("r3b_clr_n", clr_n, 0);      chk("r3b_ainc_n", ainc_n, 0);
        chk("r3b_acc_cyc", acc_cyc, 1);  chk("r3b_acc_opc", acc_opc, MD_RD);
        chk("r3b_rsp_cyc", rsp_cyc, 4);  chk("r3b_rdata", rsp_rd, 8'hC3);
        chk("r3b_rdata_held", rsp_rdata_a, 8'hC3);

        // Relocking write: reset 16 cycles, lock 40 cycles later, +2 sync, +1 resp.
        lk_en = 1'b1;
        run_req(1'b1, 1'b1, 7'd4, 8'h81);
        chk("rl_clr_first", clr_first, 1); chk("rl_ainc_n", ainc_n, 4);
        chk("rl_acc_cyc", acc_cyc, 6);   chk("rl_acc_opc", acc_opc, MD_WR);
        chk("rl_prst_first", prst_first, 7); chk("rl_prst_n", prst_n, 16);
        chk("rl_rsp_cyc", rsp_cyc, 66);  chk("rl_err", rsp_er, 0);

        // Lock held low: timeout after 100 wait cycles.
        lk_en = 1'b0;
        run_req(1'b1, 1'b1, 7'd6, 8'h42);
        chk("to_ainc_n", ainc_n, 2);     chk("to_acc_cyc", acc_cyc, 3);
        chk("to_prst_first", prst_first, 4); chk("to_prst_n", prst_n, 16);
        chk("to_rsp_cyc", rsp_cyc, 120); chk("to_err", rsp_er, 1);

        // Next request after a timeout is served normally.
        run_req(1'b1, 1'b0, 7'd6, 8'h00);
        chk("after_to_acc_cyc", acc_cyc, 1); chk("after_to_rsp_cyc", rsp_cyc, 4);
        chk("after_to_rdata", rsp_rd, 8'h77); chk("after_to_err", rsp_er, 0);

        // Async reset while stepping toward addr 127.
        sel = 1'b0;
        wait_ready();
        req_write = 1'b1; req_addr = 7'd127; req_wdata = 8'h99; req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        repeat (9) @(negedge clk);
        chk("ar_stepping", {31'd0, md_ainc_a}, 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_outs_async", {req_ready_a, rsp_valid_a, rsp_rdata_a, rsp_err_a, pll_reset_a, md_opc_a, md_ainc_a, md_wdi_a}, 0);
        begin
            int rv = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (rsp_valid_a) rv++;
            end
            resetn = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (rsp_valid_a) rv++;
            end
            chk("ar_no_rsp", rv, 0);
        end
        run_req(1'b0, 1'b1, 7'd2, 8'h11);
        chk("ar2_clr_n", clr_n, 1);      chk("ar2_clr_first", clr_first, 1);
        chk("ar2_ainc_n", ainc_n, 2);    chk("ar2_acc_cyc", acc_cyc, 4);
        chk("ar2_wdi", acc_wdi, 8'h11);  chk("ar2_rsp_cyc", rsp_cyc, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_md_ctrl.md
Name: pll_md_ctrl

Overview:
- Initiator for the PLL dynamic-reconfiguration (MD) port.
- Accepts single register read/write requests from a host (OSD/config CPU) and sequences MDOPC/MDAINC/MDWDI to reach the target register address and perform the access.
- Optionally pulses the PLL reset after a write and waits for lock, with a timeout.
- Sits beside the PLL wrapper; integration ties the PLL's MDCLK to clk.

Parameters:
- ADDR_W, 7, MD register address width
- RD_LAT, 2, clk cycles from read opcode to valid md_rdo (1..7)
- RST_CYCLES, 16, width of pll_reset pulse in clk cycles (>=1)
- LOCK_TIMEOUT, 65535, max cycles waiting for lock after reset (16-bit counter)
- RELOCK_ON_WRITE, 1, 1 = pulse pll_reset and wait lock after every write

Ports:
- clk  in  1  system clock, also drives PLL MDCLK
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  controller idle, request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target MD register
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data (held until next rsp_valid)
- rsp_err  out  1  lock timeout flag, qualified by rsp_valid
- pll_lock  in  1  PLL LOCK, asynchronous
- pll_reset  out  1  PLL RESET, active high
- md_opc  out  2  00 nop, 01 write, 10 read, 11 clear address
- md_ainc  out  1  address-increment strobe, one cycle per step
- md_wdi  out  8  write data to PLL
- md_rdo  in  8  read data from PLL

Behaviour:
- Reset values: req_ready=0 on the first cycle after deassertion, then 1; rsp_valid=0, rsp_rdata=0, rsp_err=0, pll_reset=0, md_opc=00, md_ainc=0, md_wdi=0. Tracked address cur_addr=unknown, encoded as flag addr_known=0.
- pll_lock passes through a 2-FF synchroniser; lock_s is used internally.
- States: IDLE, ADDR_CLR, ADDR_STEP, ACCESS, READ_WAIT, PLL_RST, LOCK_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On valid&ready, latch write/addr/wdata.
  - If addr_known and req_addr>=cur_addr, go to ADDR_STEP with steps=req_addr-cur_addr. Otherwise go to ADDR_CLR.
- ADDR_CLR:
  - md_opc=11 for exactly 1 cycle; cur_addr=0, addr_known=1.
  - Go to ADDR_STEP with steps=req_addr.
- ADDR_STEP:
  - md_ainc=1 for one cycle per step, back-to-back; cur_addr increments each step.
  - With steps=0, pass straight to ACCESS without a strobe.
  - req_addr=2^ADDR_W-1 needs 127 strobes; cur_addr never wraps.
- ACCESS:
  - md_opc=01 (write, md_wdi=latched data) or 10 (read) for exactly 1 cycle.
  - Read goes to READ_WAIT. Write goes to PLL_RST if RELOCK_ON_WRITE, else to RESP.
- READ_WAIT: counts RD_LAT cycles, samples md_rdo into rsp_rdata on the last one, then goes to RESP.
- PLL_RST: pll_reset=1 for RST_CYCLES cycles, then go to LOCK_WAIT with a cleared counter.
- LOCK_WAIT:
  - lock_s=1 goes to RESP with err=0.
  - Counter reaching LOCK_TIMEOUT goes to RESP with err=1.
  - A lock_s=1 on the same cycle as the timeout wins (err=0).
- RESP: rsp_valid=1 for 1 cycle with rsp_err, then return to IDLE.
- md_opc is 00 and md_ainc is 0 in every other state/cycle; opc and ainc are never both active.
- req_ready=0 in all states except IDLE; req_valid while busy is ignored (no queue).
- Latency:
  - Read from acceptance to rsp_valid = clear(0/1) + steps + 1 + RD_LAT + 1 cycles.
  - Write without relock = clear + steps + 2.
- Async reset mid-operation: all outputs return to reset values immediately, pll_reset drops, addr_known=0. No response is issued for the aborted request.
- Outputs are registered.

Decomposition:
- Shared package pll_md_pkg holds:
  - MD opcode constants (MD_NOP, MD_WR, MD_RD, MD_CLR);
  - the state enum;
  - default RD_LAT/RST_CYCLES/LOCK_TIMEOUT.
- One natural sub-module: sync2 (2-FF synchroniser for pll_lock), reusable elsewhere.
- Everything else stays in the FSM.

Test Plan:
- Write addr 5, data 0x3C from reset (RELOCK_ON_WRITE=0) -> one md_opc=11 cycle, 5 consecutive md_ainc pulses, one md_opc=01 with md_wdi=0x3C, rsp_valid 1 cycle after, rsp_err=0.
- Then read addr 9 with a PLL model returning 0xA5 after RD_LAT=2 -> no clear, 4 md_ainc pulses, md_opc=10, rsp_rdata=0xA5, total 8 cycles from accept.
- Then read addr 3 (backward) -> clear issued, 3 strobes; then read addr 3 again -> 0 strobes, md_opc=10 the cycle after accept.
- Write with RELOCK_ON_WRITE=1, lock model asserting 40 cycles after reset release -> pll_reset high exactly 16 cycles, rsp_valid after lock sync (+2), rsp_err=0.
- Lock held low, LOCK_TIMEOUT=100 -> rsp_valid with rsp_err=1 after 100 wait cycles; next request is accepted normally.
- Assert resetn low during ADDR_STEP on addr 127 -> all outputs 0 asynchronously, no rsp_valid; the next request to addr 2 starts with md_opc=11.
